// File: rtl/bcd_countdown_timer_if.sv
// bcd_countdown_timer_if: keypad/timer-input signals and MM:SS display outputs
interface bcd_countdown_timer_if;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1Hz;
  logic       enablen;
  logic       clearn;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       zero;
  logic       done;
  modport master (
    output D, loadn, pgt_1Hz, enablen, clearn,
    input  sec_ones, sec_tens, min_ones, min_tens, zero, done
  );
  modport slave (
    input  D, loadn, pgt_1Hz, enablen, clearn,
    output sec_ones, sec_tens, min_ones, min_tens, zero, done
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: MM:SS digit entry register and BCD countdown with done flag
module bcd_countdown_timer #(
  parameter logic [3:0] SEC_RELOAD_TENS = 4'd5,
  parameter logic [3:0] SEC_RELOAD_ONES = 4'd9,
  parameter logic [3:0] MAX_DIGIT       = 4'd9
) (
  input logic clk,
  input logic reset,
  bcd_countdown_timer_if.slave bus
);
  logic [3:0] so, st, mo, mt;
  logic [3:0] so_n, st_n, mo_n, mt_n;
  logic       pgt_q, zero, done, done_n, tick, key_ok, all_zero;
  assign tick     = bus.pgt_1Hz & ~pgt_q;
  assign key_ok   = ~bus.loadn && (bus.D <= MAX_DIGIT);
  assign all_zero = {mt, mo, st, so} == 16'h0;
  // next-state digits: clear beats tick; tick shifts a key in or decrements one second
  always_comb begin
    so_n = so;
    st_n = st;
    mo_n = mo;
    mt_n = mt;
    done_n = 1'b0;
    if (!bus.clearn) begin
      so_n = 4'd0;
      st_n = 4'd0;
      mo_n = 4'd0;
      mt_n = 4'd0;
    end else if (tick && bus.enablen && key_ok) begin
      mt_n = mo;
      mo_n = st;
      st_n = so;
      so_n = bus.D;
    end else if (tick && !bus.enablen && !all_zero) begin
      if (so != 4'd0) begin
        so_n = so - 4'd1;
      end else if (st != 4'd0) begin
        so_n = 4'd9;
        st_n = st - 4'd1;
      end else begin
        st_n = SEC_RELOAD_TENS;
        so_n = SEC_RELOAD_ONES;
        mo_n = (mo != 4'd0) ? mo - 4'd1 : 4'd9;
        mt_n = (mo != 4'd0) ? mt : mt - 4'd1;
      end
      done_n = {mt_n, mo_n, st_n, so_n} == 16'h0;
    end
  end
  // state registers; zero tracks the digits being loaded so it is never a cycle stale
  always_ff @(posedge clk) begin
    if (reset) begin
      so    <= 4'd0;
      st    <= 4'd0;
      mo    <= 4'd0;
      mt    <= 4'd0;
      zero  <= 1'b1;
      done  <= 1'b0;
      pgt_q <= 1'b0;
    end else begin
      so    <= so_n;
      st    <= st_n;
      mo    <= mo_n;
      mt    <= mt_n;
      zero  <= {mt_n, mo_n, st_n, so_n} == 16'h0;
      done  <= done_n;
      pgt_q <= bus.pgt_1Hz;
    end
  end
  assign bus.sec_ones = so;
  assign bus.sec_tens = st;
  assign bus.min_ones = mo;
  assign bus.min_tens = mt;
  assign bus.zero     = zero;
  assign bus.done     = done;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: scoreboard-driven checks of digit entry and countdown
module tb_bcd_countdown_timer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    string       name;
    logic [17:0] val;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  bcd_countdown_timer_if bus();
  bcd_countdown_timer dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [17:0] obs();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones, bus.zero, bus.done};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic key(input logic [3:0] d);
    bus.D = d;
    bus.loadn = 1'b0;
    bus.pgt_1Hz = 1'b1;
    cyc();
    bus.loadn = 1'b1;
    bus.pgt_1Hz = 1'b0;
    cyc();
  endtask
  task automatic clr();
    bus.clearn = 1'b0;
    cyc();
    bus.clearn = 1'b1;
  endtask
  task automatic pulse_hi();
    bus.pgt_1Hz = 1'b1;
    cyc();
  endtask
  task automatic pulse_lo();
    bus.pgt_1Hz = 1'b0;
    cyc();
  endtask
  task automatic test_reset();
    sb.push_back('{"reset", {16'h0000, 1'b1, 1'b0}});
    reset = 1'b1;
    cyc();
    cyc();
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
    reset = 1'b0;
  endtask
  task automatic test_program();
    bus.enablen = 1'b1;
    sb.push_back('{"prog_1230", {16'h1230, 1'b0, 1'b0}});
    sb.push_back('{"prog_2305", {16'h2305, 1'b0, 1'b0}});
    key(4'd1); key(4'd2); key(4'd3); key(4'd0);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
    key(4'd5);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
  endtask
  task automatic test_countdown();
    bus.enablen = 1'b1;
    clr();
    key(4'd0); key(4'd3);
    sb.push_back('{"cd_load", {16'h0003, 1'b0, 1'b0}});
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
    bus.enablen = 1'b0;
    cyc();
    sb.push_back('{"cd_0002", {16'h0002, 1'b0, 1'b0}});
    sb.push_back('{"cd_0001", {16'h0001, 1'b0, 1'b0}});
    sb.push_back('{"cd_0000_done", {16'h0000, 1'b1, 1'b1}});
    sb.push_back('{"cd_done_drop", {16'h0000, 1'b1, 1'b0}});
    sb.push_back('{"cd_hold_zero", {16'h0000, 1'b1, 1'b0}});
    for (int i = 0; i < 3; i++) begin
      pulse_hi();
      e = sb.pop_front(); n_checks++;
      if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
      pulse_lo();
      if (i == 2) begin
        e = sb.pop_front(); n_checks++;
        if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
      end
    end
    pulse_hi();
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
    pulse_lo();
  endtask
  task automatic test_borrow();
    bus.enablen = 1'b1;
    clr();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    bus.enablen = 1'b0;
    sb.push_back('{"borrow_0959", {16'h0959, 1'b0, 1'b0}});
    pulse_hi();
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
    pulse_lo();
    bus.enablen = 1'b1;
    clr();
    key(4'd1); key(4'd0); key(4'd0);
    bus.enablen = 1'b0;
    sb.push_back('{"borrow_0059", {16'h0059, 1'b0, 1'b0}});
    pulse_hi();
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
    pulse_lo();
  endtask
  task automatic test_held_pulse();
    bus.enablen = 1'b1;
    clr();
    key(4'd9); key(4'd0);
    bus.enablen = 1'b0;
    sb.push_back('{"sec90_first", {16'h0089, 1'b0, 1'b0}});
    sb.push_back('{"sec90_held", {16'h0089, 1'b0, 1'b0}});
    pulse_hi();
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
    for (int i = 0; i < 19; i++) cyc();
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
    pulse_lo();
  endtask
  task automatic test_illegal_keys();
    bus.enablen = 1'b1;
    clr();
    key(4'd1);
    sb.push_back('{"bad_digit", {16'h0001, 1'b0, 1'b0}});
    sb.push_back('{"no_loadn", {16'h0001, 1'b0, 1'b0}});
    key(4'hB);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
    bus.D = 4'd2;
    pulse_hi();
    pulse_lo();
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
  endtask
  task automatic test_clear_reset();
    bus.enablen = 1'b1;
    clr();
    key(4'd5); key(4'd1); key(4'd7);
    bus.enablen = 1'b0;
    sb.push_back('{"load_0517", {16'h0517, 1'b0, 1'b0}});
    sb.push_back('{"clear_on_tick", {16'h0000, 1'b1, 1'b0}});
    sb.push_back('{"reset_0517", {16'h0000, 1'b1, 1'b0}});
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
    bus.clearn = 1'b0;
    pulse_hi();
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
    bus.clearn = 1'b1;
    pulse_lo();
    bus.enablen = 1'b1;
    key(4'd5); key(4'd1); key(4'd7);
    bus.enablen = 1'b0;
    reset = 1'b1;
    bus.pgt_1Hz = 1'b1;
    cyc();
    reset = 1'b0;
    bus.pgt_1Hz = 1'b0;
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %h expected %h", e.name, obs(), e.val); end
  endtask
  initial begin
    bus.D = 4'd0;
    bus.loadn = 1'b1;
    bus.pgt_1Hz = 1'b0;
    bus.enablen = 1'b1;
    bus.clearn = 1'b1;
    test_reset();
    test_program();
    test_countdown();
    test_borrow();
    test_held_pulse();
    test_illegal_keys();
    test_clear_reset();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: observed %0d leftover entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Consumer side of the keypad/timer-input interface in the microwave controller.
- Takes the BCD digit D, the key-valid strobe loadn and the timing pulse pgt_1Hz produced by the timer-input encoder.
- In programming mode it shifts entered digits into an MM:SS register. In cooking mode it counts MM:SS down to 00:00 and flags completion.
- Outputs drive the display decoders and the oven control FSM.

Parameters:
- SEC_RELOAD_TENS, 5, seconds-tens value loaded on a minute borrow.
- SEC_RELOAD_ONES, 9, seconds-ones value loaded on a minute borrow.
- MAX_DIGIT, 9, largest legal BCD digit; larger D values are ignored.

Ports:
- clk  input  1  system clock; every register is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- D  input  4  BCD digit from the keypad encoder.
- loadn  input  1  active-low: a key is pressed and D is valid.
- pgt_1Hz  input  1  timing pulse from the encoder: key strobe in programming mode, 1 Hz in cooking mode.
- enablen  input  1  active-low: 0 = cooking (count down), 1 = programming (load).
- clearn  input  1  active-low synchronous clear of the time registers.
- sec_ones  output  4  seconds units, BCD.
- sec_tens  output  4  seconds tens, BCD.
- min_ones  output  4  minutes units, BCD.
- min_tens  output  4  minutes tens, BCD.
- zero  output  1  high while all four digits are 0.
- done  output  1  one-cycle pulse when a countdown reaches 00:00.

Behaviour:
- Reset (reset=1 at a clk edge):
  - all digits become 0, zero=1, done=0, pgt_q=0.
  - reset has priority over every other input.
- Edge detect:
  - pgt_q registers pgt_1Hz every cycle.
  - tick = pgt_1Hz & ~pgt_q, i.e. one tick per rising edge of pgt_1Hz. A level held high gives exactly one tick.
  - Registers update on the same clk edge where tick=1, so the new value is visible in the next cycle (latency 1 clk from pgt_1Hz rising).
- Priority per edge: reset > clearn=0 > tick action > hold.
- clearn=0: all digits become 0 and done=0, regardless of tick or mode.
- Programming mode (enablen=1), on tick with loadn=0 and D<=MAX_DIGIT:
  - shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D.
  - the old min_tens is discarded.
- Programming mode, other cases:
  - tick with loadn=1 or D>MAX_DIGIT: hold.
  - done is never asserted in this mode.
- Cooking mode (enablen=0), on tick, BCD decrement of MM:SS:
  - already 00:00: hold, no done.
  - sec_ones>0: sec_ones-1.
  - else sec_tens>0: sec_ones<=9, sec_tens-1.
  - else minutes>0: seconds<=SEC_RELOAD_TENS:SEC_RELOAD_ONES, and minutes decrement in BCD (min_ones>0 ? min_ones-1 : min_ones<=9, min_tens-1).
- Seconds range:
  - sec_tens up to 9 is legal when loaded (e.g. 00:90 counts down through 00:89).
  - only a minute borrow reloads the seconds to 59.
- done: 1 for exactly the one cycle after a decrement that produced 00:00 from a nonzero value; 0 otherwise.
- zero: registered, and equal to (all digits == 0) in every cycle, including the cycle after reset.
- Mode changes take effect on the next tick. The pgt_q history is kept across mode switches, so a pulse already high when the mode changes does not create a tick.
- Arithmetic is per-digit 4-bit BCD; no binary intermediate; no digit ever exceeds 9.

Test Plan:
- Reset, then enablen=1; keys 1,2,3,0 each as loadn=0 with one pgt_1Hz pulse -> digits read 12:30, zero=0; a fifth key 5 -> 23:05.
- Load 00:03, enablen=0, three pgt_1Hz pulses:
  - outputs go 00:02, 00:01, 00:00;
  - done high for exactly 1 cycle after the third pulse; zero=1;
  - a fourth pulse holds 00:00 with no done.
- Load 10:00, enablen=0, one pulse -> 09:59. Load 01:00, one pulse -> 00:59.
- Load 00:90 (keys 9,0), count -> 00:89; pgt_1Hz held high for 20 cycles -> only one decrement.
- Programming mode: D=4'hB with loadn=0 plus a pulse -> no change. loadn=1 plus a pulse -> no change.
- Mid-countdown at 05:17:
  - clearn=0 in the same cycle as a tick -> 00:00, done=0;
  - reset=1 at 05:17 -> 00:00, zero=1 next cycle, done=0.
